instr_reg_ctrl: RTL and testbench

Controller for the instruction register. It arbitrates write-port access among NREQ requesters using round-robin, and drives the registered write port (load_en, write_pointer, operands, opcode). It also contains a sequencer that, on start, walks a pointer range and issues each slot to a downstream execution unit with a valid/ready handshake. It sits between the stimulus/loader agents and the instruction register, and between the instruction register and the execute stage.

---
 rtl/instr_reg_ctrl_if.sv | 56 +++++
 rtl/instr_reg_ctrl.sv | 152 +++++++++++++++
 tb/tb_instr_reg_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_reg_ctrl_if.sv
// Bus bundle for the instruction register controller: requester write
// channel, instruction register ports, sequencer control and issue handshake.
interface instr_reg_ctrl_if #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 5,
    parameter int OP_W  = 32,
    parameter int OPC_W = 4
) ();
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*PTR_W-1:0] req_ptr;
    logic [NREQ*OP_W-1:0]  req_opa;
    logic [NREQ*OP_W-1:0]  req_opb;
    logic [NREQ*OPC_W-1:0] req_opc;

    logic                  ir_load_en;
    logic [PTR_W-1:0]      ir_write_pointer;
    logic [OP_W-1:0]       ir_operand_a;
    logic [OP_W-1:0]       ir_operand_b;
    logic [OPC_W-1:0]      ir_opcode;
    logic [PTR_W-1:0]      ir_read_pointer;

    logic                  seq_start;
    logic [PTR_W-1:0]      seq_first;
    logic [PTR_W-1:0]      seq_last;
    logic                  seq_busy;
    logic                  seq_done;

    logic                  issue_valid;
    logic                  issue_ready;
    logic [PTR_W-1:0]      issue_ptr;

    // Controller side
    modport master (
        input  req_valid, req_ptr, req_opa, req_opb, req_opc,
        output req_ready,
        output ir_load_en, ir_write_pointer, ir_operand_a, ir_operand_b,
               ir_opcode, ir_read_pointer,
        input  seq_start, seq_first, seq_last,
        output seq_busy, seq_done,
        output issue_valid, issue_ptr,
        input  issue_ready
    );

    // Requesters, instruction register and execute stage side
    modport slave (
        output req_valid, req_ptr, req_opa, req_opb, req_opc,
        input  req_ready,
        input  ir_load_en, ir_write_pointer, ir_operand_a, ir_operand_b,
               ir_opcode, ir_read_pointer,
        output seq_start, seq_first, seq_last,
        input  seq_busy, seq_done,
        input  issue_valid, issue_ptr,
        output issue_ready
    );
endinterface

// File: rtl/instr_reg_ctrl.sv
// Instruction register controller: round-robin write-port arbiter with a
// registered write port, plus a sweep sequencer that issues register slots
// to the execute stage and stalls on pending writes to the slot it offers.
module instr_reg_ctrl #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 5,
    parameter int OP_W  = 32,
    parameter int OPC_W = 4
) (
    input logic              clk,
    input logic              reset,
    instr_reg_ctrl_if.master bus
);
    localparam int RR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

    logic [RR_W-1:0]  rr_ptr;
    logic [NREQ-1:0]  grant;
    logic [RR_W-1:0]  gnt_idx;
    logic             xfer;
    logic [PTR_W-1:0] gnt_ptr;

    logic             load_en_q;
    logic [PTR_W-1:0] wp_q;
    logic [OP_W-1:0]  opa_q;
    logic [OP_W-1:0]  opb_q;
    logic [OPC_W-1:0] opc_q;

    seq_state_t       state_q;
    seq_state_t       state_d;
    logic [PTR_W-1:0] cur_q;
    logic [PTR_W-1:0] last_q;
    logic             held_q;
    logic             hazard;
    logic             issue_valid;
    logic             accept;

    // Round-robin search starting at rr_ptr; grants are suppressed during reset
    always_comb begin
        int idx;
        idx     = 0;
        grant   = '0;
        gnt_idx = '0;
        xfer    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!xfer && !reset && bus.req_valid[idx]) begin
                xfer       = 1'b1;
                grant[idx] = 1'b1;
                gnt_idx    = idx[RR_W-1:0];
            end
        end
    end

    assign gnt_ptr       = bus.req_ptr[int'(gnt_idx)*PTR_W +: PTR_W];
    assign bus.req_ready = grant;

    // Register the granted payload and advance the round-robin pointer past the winner
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= '0;
            load_en_q <= 1'b0;
            wp_q      <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            opc_q     <= '0;
        end else begin
            load_en_q <= xfer;
            if (xfer) begin
                wp_q   <= gnt_ptr;
                opa_q  <= bus.req_opa[int'(gnt_idx)*OP_W +: OP_W];
                opb_q  <= bus.req_opb[int'(gnt_idx)*OP_W +: OP_W];
                opc_q  <= bus.req_opc[int'(gnt_idx)*OPC_W +: OPC_W];
                rr_ptr <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + RR_W'(1);
            end
        end
    end

    assign bus.ir_load_en       = load_en_q;
    assign bus.ir_write_pointer = wp_q;
    assign bus.ir_operand_a     = opa_q;
    assign bus.ir_operand_b     = opb_q;
    assign bus.ir_opcode        = opc_q;

    // A slot is unsafe to offer while a write to it is granted now or is being committed
    assign hazard = (xfer && (gnt_ptr == cur_q)) || (load_en_q && (wp_q == cur_q));

    // Sequencer next state and issue handshake; an offer already made is held until taken
    always_comb begin
        state_d     = state_q;
        issue_valid = 1'b0;
        accept      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.seq_start) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                issue_valid = held_q || !hazard;
                accept      = issue_valid && bus.issue_ready;
                if (accept && (cur_q == last_q)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sweep bounds, current slot and the offer-held flag
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q  <= '0;
            last_q <= '0;
            held_q <= 1'b0;
        end else begin
            held_q <= issue_valid && !bus.issue_ready;
            if ((state_q == IDLE) && bus.seq_start) begin
                cur_q  <= bus.seq_first;
                last_q <= bus.seq_last;
            end else if (accept && (cur_q != last_q)) begin
                cur_q <= cur_q + PTR_W'(1);
            end
        end
    end

    assign bus.issue_valid     = issue_valid;
    assign bus.issue_ptr       = cur_q;
    assign bus.ir_read_pointer = cur_q;
    assign bus.seq_busy        = (state_q != IDLE);
    assign bus.seq_done        = (state_q == DONE);

endmodule

// File: tb/tb_instr_reg_ctrl.sv
// Testbench for instr_reg_ctrl: directed scenarios with literal expectations
// plus a queue-based behavioural model compared on every non-reset cycle.
module tb_instr_reg_ctrl;
    localparam int NREQ  = 4;
    localparam int PTR_W = 5;
    localparam int OP_W  = 32;
    localparam int OPC_W = 4;
    localparam int DEPTH = 1 << PTR_W;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   stamp;

    instr_reg_ctrl_if #(.NREQ(NREQ), .PTR_W(PTR_W), .OP_W(OP_W), .OPC_W(OPC_W)) bus ();

    instr_reg_ctrl #(.NREQ(NREQ), .PTR_W(PTR_W), .OP_W(OP_W), .OPC_W(OPC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [PTR_W-1:0] payPtr(int s, int i);
        return PTR_W'((s * 3 + i * 5) % DEPTH);
    endfunction

    function automatic logic [OP_W-1:0] payOpa(int s, int i);
        return OP_W'(32'hA000_0000 + s * 16 + i);
    endfunction

    function automatic logic [OP_W-1:0] payOpb(int s, int i);
        return OP_W'(32'h5000_0000 ^ (s << 8) ^ i);
    endfunction

    function automatic logic [OPC_W-1:0] payOpc(int s, int i);
        return OPC_W'(s + i);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive request valids with a fresh payload on every requester
    task automatic applyStimulus(input logic [NREQ-1:0] v);
        stamp++;
        bus.req_valid = v;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_ptr[i*PTR_W +: PTR_W] = payPtr(stamp, i);
            bus.req_opa[i*OP_W +: OP_W]   = payOpa(stamp, i);
            bus.req_opb[i*OP_W +: OP_W]   = payOpb(stamp, i);
            bus.req_opc[i*OPC_W +: OPC_W] = payOpc(stamp, i);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    int               m_rr;
    bit               m_load;
    logic [PTR_W-1:0] m_wp;
    logic [OP_W-1:0]  m_opa;
    logic [OP_W-1:0]  m_opb;
    logic [OPC_W-1:0] m_opc;
    int               m_q[$];
    bit               m_done;
    bit               m_offered;

    // Compare DUT against the model mid-cycle, then advance the model as the next edge will
    always @(negedge clk) begin
        int               gi;
        logic [NREQ-1:0]  exp_ready;
        bit               in_issue;
        bit               idle;
        bit               hz;
        bit               ev;
        int               cur;
        int               p;
        if (reset) begin
            m_rr = 0; m_load = 0; m_wp = '0; m_opa = '0; m_opb = '0; m_opc = '0;
            m_q.delete(); m_done = 0; m_offered = 0;
        end else begin
            gi = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (gi < 0 && bus.req_valid[(m_rr + k) % NREQ]) gi = (m_rr + k) % NREQ;
            end
            exp_ready = '0;
            if (gi >= 0) exp_ready[gi] = 1'b1;
            checkOutput("m_req_ready", bus.req_ready, exp_ready);
            checkOutput("m_load_en", bus.ir_load_en, m_load);
            checkOutput("m_wp", bus.ir_write_pointer, m_wp);
            checkOutput("m_opa", bus.ir_operand_a, m_opa);
            checkOutput("m_opb", bus.ir_operand_b, m_opb);
            checkOutput("m_opc", bus.ir_opcode, m_opc);

            in_issue = (m_q.size() > 0);
            idle     = !in_issue && !m_done;
            cur      = in_issue ? m_q[0] : 0;
            hz = ((gi >= 0) && (int'(bus.req_ptr[gi*PTR_W +: PTR_W]) == cur))
                 || (m_load && (int'(m_wp) == cur));
            ev = in_issue && (m_offered || !hz);
            checkOutput("m_issue_valid", bus.issue_valid, ev);
            checkOutput("m_seq_done", bus.seq_done, m_done);
            checkOutput("m_seq_busy", bus.seq_busy, in_issue || m_done);
            if (ev) begin
                checkOutput("m_issue_ptr", bus.issue_ptr, cur);
                checkOutput("m_read_ptr", bus.ir_read_pointer, cur);
            end

            m_done = 0;
            if (in_issue) begin
                if (ev && bus.issue_ready) begin
                    void'(m_q.pop_front());
                    m_offered = 0;
                    if (m_q.size() == 0) m_done = 1;
                end else begin
                    m_offered = ev;
                end
            end else if (idle && bus.seq_start) begin
                p = int'(bus.seq_first);
                for (int n = 0; n < DEPTH; n++) begin
                    m_q.push_back(p);
                    if (p == int'(bus.seq_last)) break;
                    p = (p + 1) % DEPTH;
                end
                m_offered = 0;
            end

            m_load = (gi >= 0);
            if (gi >= 0) begin
                m_wp  = bus.req_ptr[gi*PTR_W +: PTR_W];
                m_opa = bus.req_opa[gi*OP_W +: OP_W];
                m_opb = bus.req_opb[gi*OP_W +: OP_W];
                m_opc = bus.req_opc[gi*OPC_W +: OPC_W];
                m_rr  = (gi + 1) % NREQ;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int s;
        int wrap_ptrs[4];
        checks = 0; failures = 0; stamp = 0;
        reset = 1'b1;
        bus.seq_start = 1'b0; bus.seq_first = '0; bus.seq_last = '0; bus.issue_ready = 1'b0;
        applyStimulus('0);
        step();

        // Reset values
        @(negedge clk);
        checkOutput("rst_ready", bus.req_ready, 0);
        checkOutput("rst_load", bus.ir_load_en, 0);
        checkOutput("rst_busy", bus.seq_busy, 0);
        checkOutput("rst_valid", bus.issue_valid, 0);
        checkOutput("rst_issue_ptr", bus.issue_ptr, 0);
        checkOutput("rst_wp", bus.ir_write_pointer, 0);
        step();
        reset = 1'b0;

        // Round-robin with everyone requesting
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b1111);
            s = stamp;
            @(negedge clk);
            checkOutput("rr_ready", bus.req_ready, 64'(1) << (k % 4));
            if (k > 0) begin
                checkOutput("rr_load", bus.ir_load_en, 1);
                checkOutput("rr_wp", bus.ir_write_pointer, payPtr(s - 1, (k - 1) % 4));
                checkOutput("rr_opa", bus.ir_operand_a, payOpa(s - 1, (k - 1) % 4));
                checkOutput("rr_opc", bus.ir_opcode, payOpc(s - 1, (k - 1) % 4));
            end
            step();
        end
        applyStimulus('0);
        s = stamp;
        @(negedge clk);
        checkOutput("rr_tail_load", bus.ir_load_en, 1);
        checkOutput("rr_tail_opb", bus.ir_operand_b, payOpb(s - 1, 3));
        step();

        // Sparse requests: move rr_ptr to 2, then only 1 and 3 request
        applyStimulus(4'b0010);
        @(negedge clk);
        checkOutput("sp_ready0", bus.req_ready, 4'b0010);
        checkOutput("sp_idle_load", bus.ir_load_en, 0);
        step();
        applyStimulus(4'b1010);
        s = stamp;
        @(negedge clk);
        checkOutput("sp_ready1", bus.req_ready, 4'b1000);
        checkOutput("sp_wp1", bus.ir_write_pointer, payPtr(s - 1, 1));
        step();
        applyStimulus(4'b1010);
        s = stamp;
        @(negedge clk);
        checkOutput("sp_ready2", bus.req_ready, 4'b0010);
        checkOutput("sp_wp2", bus.ir_write_pointer, payPtr(s - 1, 3));
        step();
        applyStimulus(4'b1010);
        s = stamp;
        @(negedge clk);
        checkOutput("sp_ready3", bus.req_ready, 4'b1000);
        checkOutput("sp_wp3", bus.ir_write_pointer, payPtr(s - 1, 1));
        step();
        applyStimulus('0);
        s = stamp;
        @(negedge clk);
        checkOutput("sp_wp4", bus.ir_write_pointer, payPtr(s - 1, 3));
        step();
        @(negedge clk);
        checkOutput("sp_load_off", bus.ir_load_en, 0);
        checkOutput("sp_wp_hold", bus.ir_write_pointer, payPtr(s - 1, 3));
        step();

        // Reset in the middle of a sweep with all requesters active
        bus.seq_first = 5'd10; bus.seq_last = 5'd20; bus.seq_start = 1'b1; bus.issue_ready = 1'b0;
        step();
        bus.seq_start = 1'b0;
        applyStimulus(4'b1111);
        step();
        reset = 1'b1;
        step();
        step();
        @(negedge clk);
        checkOutput("mr_ready", bus.req_ready, 0);
        checkOutput("mr_load", bus.ir_load_en, 0);
        checkOutput("mr_opa", bus.ir_operand_a, 0);
        checkOutput("mr_busy", bus.seq_busy, 0);
        checkOutput("mr_done", bus.seq_done, 0);
        checkOutput("mr_valid", bus.issue_valid, 0);
        step();
        reset = 1'b0;
        applyStimulus(4'b1111);
        @(negedge clk);
        checkOutput("mr_first_grant", bus.req_ready, 4'b0001);
        step();
        applyStimulus('0);
        step();
        step();

        // Wrapping sweep 30..1 with the execute stage always ready
        wrap_ptrs = '{30, 31, 0, 1};
        bus.seq_first = 5'd30; bus.seq_last = 5'd1; bus.seq_start = 1'b1; bus.issue_ready = 1'b1;
        @(negedge clk);
        checkOutput("wr_busy_pre", bus.seq_busy, 0);
        step();
        bus.seq_start = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            checkOutput("wr_valid", bus.issue_valid, 1);
            checkOutput("wr_ptr", bus.issue_ptr, wrap_ptrs[j]);
            step();
        end
        @(negedge clk);
        checkOutput("wr_done", bus.seq_done, 1);
        checkOutput("wr_busy_done", bus.seq_busy, 1);
        checkOutput("wr_valid_done", bus.issue_valid, 0);
        step();
        @(negedge clk);
        checkOutput("wr_done_off", bus.seq_done, 0);
        checkOutput("wr_busy_off", bus.seq_busy, 0);
        step();

        // Backpressure on sweep 4..5 with an ignored restart attempt
        bus.seq_first = 5'd4; bus.seq_last = 5'd5; bus.seq_start = 1'b1; bus.issue_ready = 1'b0;
        step();
        bus.seq_start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            if (j == 1) begin
                bus.seq_start = 1'b1; bus.seq_first = 5'd20; bus.seq_last = 5'd25;
            end
            @(negedge clk);
            checkOutput("bp_valid", bus.issue_valid, 1);
            checkOutput("bp_ptr", bus.issue_ptr, 4);
            step();
            bus.seq_start = 1'b0;
        end
        bus.issue_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_ptr_acc", bus.issue_ptr, 4);
        step();
        @(negedge clk);
        checkOutput("bp_ptr_next", bus.issue_ptr, 5);
        checkOutput("bp_valid_next", bus.issue_valid, 1);
        step();
        @(negedge clk);
        checkOutput("bp_done", bus.seq_done, 1);
        step();
        @(negedge clk);
        checkOutput("bp_busy_off", bus.seq_busy, 0);
        step();

        // Write hazard on single-slot sweep 7..7
        bus.seq_first = 5'd7; bus.seq_last = 5'd7; bus.seq_start = 1'b1; bus.issue_ready = 1'b1;
        step();
        bus.seq_start = 1'b0;
        applyStimulus(4'b0100);
        bus.req_ptr[2*PTR_W +: PTR_W] = 5'd7;
        @(negedge clk);
        checkOutput("hz_grant", bus.req_ready, 4'b0100);
        checkOutput("hz_valid0", bus.issue_valid, 0);
        step();
        applyStimulus('0);
        @(negedge clk);
        checkOutput("hz_load", bus.ir_load_en, 1);
        checkOutput("hz_wp", bus.ir_write_pointer, 7);
        checkOutput("hz_valid1", bus.issue_valid, 0);
        step();
        @(negedge clk);
        checkOutput("hz_valid2", bus.issue_valid, 1);
        checkOutput("hz_ptr", bus.issue_ptr, 7);
        step();
        @(negedge clk);
        checkOutput("hz_done", bus.seq_done, 1);
        checkOutput("hz_valid3", bus.issue_valid, 0);
        step();
        @(negedge clk);
        checkOutput("hz_busy_off", bus.seq_busy, 0);
        step();

        // Mixed concurrent traffic, checked by the model alone
        for (int c = 0; c < 80; c++) begin
            applyStimulus(NREQ'($urandom));
            bus.issue_ready = 1'($urandom_range(0, 1));
            bus.seq_start   = ($urandom_range(0, 3) == 0);
            bus.seq_first   = PTR_W'($urandom);
            bus.seq_last    = bus.seq_first + PTR_W'($urandom_range(0, 5));
            step();
        end
        bus.seq_start = 1'b0;
        applyStimulus('0);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
